// File: rtl/mem_delay_line_pkg.sv
// Shared types for the circular-buffer delay line.
package mem_delay_line_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/delay_slew.sv
// Delay register that moves toward its target by at most SLEW_STEP per tick.
module delay_slew #(
    parameter int W         = 16,
    parameter int SLEW_STEP = 1
) (
    input  logic         clk_i,
    input  logic         srst_i,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] target,
    output logic [W-1:0] current,
    output logic [W-1:0] nxt
);

    localparam logic [W-1:0] STEP = W'(SLEW_STEP);

    // nxt is the value current takes on this edge; the read address uses it.
    always_comb begin
        nxt = current;
        if (tick) begin
            if (target >= current) begin
                if ((target - current) <= STEP) nxt = target;
                else                            nxt = current + STEP;
            end else begin
                if ((current - target) <= STEP) nxt = target;
                else                            nxt = current - STEP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i || clr) current <= '0;
        else               current <= nxt;
    end

endmodule

// File: rtl/mem_delay_line.sv
// Circular-buffer delay line driving one board_memory master channel per sample tick.
module mem_delay_line
    import mem_delay_line_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 22,
    parameter int DEPTH_LOG2 = 16,
    parameter int BASE_ADDR  = 0,
    parameter int SLEW_STEP  = 1
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  ready_i,
    input  logic                  sample_tick_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic [DEPTH_LOG2-1:0] delay_i,
    output logic [ADDR_WIDTH-1:0] mem_write_address_o,
    output logic [ADDR_WIDTH-1:0] mem_read_address_o,
    output logic [DATA_WIDTH-1:0] mem_writedata_o,
    output logic                  mem_write_enable_o,
    input  logic [DATA_WIDTH-1:0] mem_readdata_i,
    output logic [DATA_WIDTH-1:0] sample_o,
    output logic                  sample_valid_o
);

    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [DEPTH_LOG2:0]   FILL_LAST = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - 1);

    state_t                  state;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   cur_delay;
    logic [DEPTH_LOG2-1:0]   nxt_delay;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     fill_cnt;
    logic                    advance;

    function automatic logic [ADDR_WIDTH-1:0] region_addr(input logic [DEPTH_LOG2-1:0] ptr);
        return BASE + ADDR_WIDTH'(ptr);
    endfunction

    assign advance = (state != ST_IDLE) && ready_i && sample_tick_i;
    assign rd_ptr  = wr_ptr - nxt_delay;

    delay_slew #(
        .W         (DEPTH_LOG2),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .clr     (!ready_i),
        .tick    (advance),
        .target  (delay_i),
        .current (cur_delay),
        .nxt     (nxt_delay)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i || !ready_i) begin
            state               <= ST_IDLE;
            wr_ptr              <= '0;
            fill_cnt            <= '0;
            mem_write_address_o <= BASE;
            mem_read_address_o  <= BASE;
            mem_writedata_o     <= '0;
            mem_write_enable_o  <= 1'b0;
            sample_o            <= '0;
            sample_valid_o      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state              <= ST_FILL;
                    fill_cnt           <= '0;
                    mem_write_enable_o <= 1'b1;
                end
                default: begin
                    if (sample_tick_i) begin
                        mem_writedata_o     <= sample_i;
                        wr_ptr              <= wr_ptr + 1'b1;
                        mem_write_address_o <= region_addr(wr_ptr);
                        mem_read_address_o  <= region_addr(rd_ptr);
                        if (state == ST_RUN) begin
                            sample_o       <= mem_readdata_i;
                            sample_valid_o <= 1'b1;
                        end else begin
                            sample_o       <= '0;
                            sample_valid_o <= 1'b0;
                        end
                    end
                    // Flush overrides the fill count and mute even on a tick; the write still lands.
                    if (flush_i) begin
                        state          <= ST_FILL;
                        fill_cnt       <= '0;
                        sample_o       <= '0;
                        sample_valid_o <= 1'b0;
                    end else if (sample_tick_i && state == ST_FILL) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == FILL_LAST) state <= ST_RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_delay_line.sv
// Directed bench for mem_delay_line with an ideal write-first memory and a sample scoreboard.
module tb_mem_delay_line;

    localparam int DW   = 24;
    localparam int AW   = 22;
    localparam int DL2  = 4;
    localparam int BASE = 16;

    logic           clk;
    logic           srst;
    logic           ready;
    logic           sample_tick;
    logic           flush;
    logic [DW-1:0]  sample_in;
    logic [DL2-1:0] delay;
    logic [AW-1:0]  waddr;
    logic [AW-1:0]  raddr;
    logic [DW-1:0]  wdata;
    logic           we;
    logic [DW-1:0]  rdata;
    logic [DW-1:0]  sample_out;
    logic           valid;

    mem_delay_line #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH_LOG2 (DL2),
        .BASE_ADDR  (BASE),
        .SLEW_STEP  (1)
    ) dut (
        .clk_i               (clk),
        .srst_i              (srst),
        .ready_i             (ready),
        .sample_tick_i       (sample_tick),
        .flush_i             (flush),
        .sample_i            (sample_in),
        .delay_i             (delay),
        .mem_write_address_o (waddr),
        .mem_read_address_o  (raddr),
        .mem_writedata_o     (wdata),
        .mem_write_enable_o  (we),
        .mem_readdata_i      (rdata),
        .sample_o            (sample_out),
        .sample_valid_o      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal memory: latches on the tick cycle, read-during-write returns new data.
    logic [DW-1:0] mem [0:63];
    always @(posedge clk) begin
        if (sample_tick) begin
            if (we) mem[waddr[5:0]] <= wdata;
            rdata <= (we && waddr == raddr) ? wdata : mem[raddr[5:0]];
        end
    end

    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } sb_t;

    sb_t           sb_q[$];
    logic [DW-1:0] hist [0:1023];
    int            checks   = 0;
    int            failures = 0;
    int            tick_n   = 0;
    int            exp_cd   = 0;
    int            filled   = 0;
    bit            running  = 0;
    bit            exp_valid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic session_clear();
        tick_n    = 0;
        exp_cd    = 0;
        filled    = 0;
        running   = 0;
        exp_valid = 0;
        sb_q.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"},    32'(we), 32'd0);
        chk({tag, "_waddr"}, 32'(waddr), BASE);
        chk({tag, "_raddr"}, 32'(raddr), BASE);
        chk({tag, "_wdata"}, 32'(wdata), 32'd0);
        chk({tag, "_sout"},  32'(sample_out), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
    endtask

    task automatic do_tick(input bit fl);
        logic [DW-1:0] s;
        int            tgt;
        int            src;
        sb_t           e;
        s = DW'($urandom);
        tick_n++;
        hist[tick_n] = s;
        tgt = int'(delay);
        if ((tgt - exp_cd) <= 1 && (exp_cd - tgt) <= 1) exp_cd = tgt;
        else if (tgt > exp_cd)                          exp_cd = exp_cd + 1;
        else                                            exp_cd = exp_cd - 1;
        if (fl) begin
            running   = 0;
            filled    = 0;
            exp_valid = 0;
        end else if (running) begin
            exp_valid = 1;
        end else begin
            exp_valid = 0;
            filled++;
            if (filled == 16) running = 1;
        end
        src = tick_n - exp_cd;
        e.due = tick_n + 2;
        e.val = (src >= 1) ? hist[src] : '0;
        sb_q.push_back(e);

        @(negedge clk);
        sample_tick = 1'b1;
        sample_in   = s;
        flush       = fl;
        @(negedge clk);
        sample_tick = 1'b0;
        flush       = 1'b0;

        chk("waddr", 32'(waddr), 32'(BASE + ((tick_n - 1) & 15)));
        chk("wdata", 32'(wdata), 32'(s));
        chk("we",    32'(we), 32'd1);
        chk("dgap",  32'((waddr - raddr) & 22'd15), 32'(exp_cd));
        chk("valid", 32'(valid), 32'(exp_valid));
        while (sb_q.size() > 0 && sb_q[0].due <= tick_n) begin
            e = sb_q.pop_front();
            if (exp_valid && e.due == tick_n) chk("data", 32'(sample_out), 32'(e.val));
        end
        if (!exp_valid) chk("mute", 32'(sample_out), 32'd0);
    endtask

    initial begin
        srst        = 1'b1;
        ready       = 1'b0;
        sample_tick = 1'b0;
        flush       = 1'b0;
        sample_in   = '0;
        delay       = 4'd3;
        repeat (3) @(negedge clk);
        chk_idle_outputs("rst");
        srst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("idle");

        // Start: write enable rises on the IDLE->FILL cycle before any tick.
        ready = 1'b1;
        @(negedge clk);
        chk("start_we",    32'(we), 32'd1);
        chk("start_waddr", 32'(waddr), BASE);
        session_clear();

        repeat (24) do_tick(1'b0);

        delay = 4'd2;
        repeat (4) do_tick(1'b0);
        delay = 4'd9;
        repeat (14) do_tick(1'b0);

        // Flush on a tick: the sample still lands and exactly 16 further ticks stay muted.
        do_tick(1'b1);
        repeat (20) do_tick(1'b0);

        // ready drop mid-RUN returns to IDLE; re-arm restarts from wr_ptr 0.
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        chk_idle_outputs("drop");
        ready = 1'b1;
        @(negedge clk);
        chk("rearm_we", 32'(we), 32'd1);
        session_clear();
        repeat (5) do_tick(1'b0);

        // Synchronous reset coincident with a tick in FILL.
        @(negedge clk);
        srst        = 1'b1;
        sample_tick = 1'b1;
        sample_in   = 24'hABCDEF;
        @(negedge clk);
        srst        = 1'b0;
        sample_tick = 1'b0;
        chk_idle_outputs("srst_tick");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
